// File: rtl/fsm_seq_pkg.sv
// Shared elaboration-time helpers for the serial pattern detector:
// state width and KMP border / transition functions.
package fsm_seq_pkg;

    localparam int MAX_LEN = 16;

    function automatic int state_w(input int len);
        return $clog2(len + 1);
    endfunction

    // Longest proper border: largest k < len with prefix(k) == suffix(k).
    function automatic int border(input logic [MAX_LEN-1:0] pat, input int len);
        bit ok;
        for (int k = len - 1; k > 0; k--) begin
            ok = 1'b1;
            for (int j = 0; j < k; j++) begin
                if (pat[len-1-j] != pat[k-1-j]) begin
                    ok = 1'b0;
                end
            end
            if (ok) begin
                return k;
            end
        end
        return 0;
    endfunction

    // Next matched-prefix length after the first s pattern bits are followed by b.
    function automatic int kmp_next(input logic [MAX_LEN-1:0] pat, input int len,
                                    input int s, input logic b);
        logic [MAX_LEN:0] seq;
        int  m;
        bit  ok;
        seq = '0;
        m   = s + 1;
        for (int i = 0; i < s; i++) begin
            seq[i] = pat[len-1-i];
        end
        seq[s] = b;
        for (int k = (m > len) ? len : m; k > 0; k--) begin
            ok = 1'b1;
            for (int j = 0; j < k; j++) begin
                if (seq[m-k+j] != pat[len-1-j]) begin
                    ok = 1'b0;
                end
            end
            if (ok) begin
                return k;
            end
        end
        return 0;
    endfunction

endpackage

// File: rtl/fsm_seq_next_lut.sv
// Combinational transition table for fsm_seq_det; every entry is a constant
// derived from PATTERN at elaboration, unused encodings fall back to 0.
module fsm_seq_next_lut
    import fsm_seq_pkg::*;
#(
    parameter int              LEN     = 4,
    parameter logic [LEN-1:0]  PATTERN = 4'b1011,
    parameter int              OVERLAP = 1,
    parameter int              SW      = state_w(LEN)
) (
    input  logic [SW-1:0] state,
    input  logic          in,
    output logic [SW-1:0] state_next
);

    localparam int                 NS     = 1 << SW;
    localparam logic [MAX_LEN-1:0] PAT    = MAX_LEN'(PATTERN);
    localparam int                 BORDER = border(PAT, LEN);

    logic [NS-1:0][SW-1:0] lut0;
    logic [NS-1:0][SW-1:0] lut1;

    for (genvar gi = 0; gi < NS; gi++) begin : g_lut
        if (gi < LEN) begin : g_prefix
            localparam int N0 = kmp_next(PAT, LEN, gi, 1'b0);
            localparam int N1 = kmp_next(PAT, LEN, gi, 1'b1);
            assign lut0[gi] = SW'(N0);
            assign lut1[gi] = SW'(N1);
        end else if (gi == LEN) begin : g_full
            // After a full match either continue from the border or start over.
            localparam int FROM = (OVERLAP != 0) ? BORDER : 0;
            localparam int N0   = kmp_next(PAT, LEN, FROM, 1'b0);
            localparam int N1   = kmp_next(PAT, LEN, FROM, 1'b1);
            assign lut0[gi] = SW'(N0);
            assign lut1[gi] = SW'(N1);
        end else begin : g_unused
            assign lut0[gi] = '0;
            assign lut1[gi] = '0;
        end
    end

    assign state_next = in ? lut1[state] : lut0[state];

endmodule

// File: rtl/fsm_seq_det.sv
// Serial pattern detector (Moore, KMP fallback). Define FSM_MATCH_COUNT_EN
// to add the saturating match_cnt output and its counter.
module fsm_seq_det
    import fsm_seq_pkg::*;
#(
    parameter int             LEN     = 4,
    parameter logic [LEN-1:0] PATTERN = 4'b1011,
    parameter int             OVERLAP = 1,
    parameter int             CNT_W   = 8
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     en,
    input  logic                     in,
    output logic                     out,
    output logic [state_w(LEN)-1:0]  state_o
`ifdef FSM_MATCH_COUNT_EN
    ,
    output logic [CNT_W-1:0]         match_cnt
`endif
);

    localparam int SW = state_w(LEN);

    if (LEN < 2 || LEN > MAX_LEN || CNT_W < 1) begin : g_bad_params
        $error("fsm_seq_det: LEN must be 2..16 and CNT_W at least 1");
    end

    logic [SW-1:0] state_reg;
    logic [SW-1:0] state_next;
    logic [SW-1:0] lut_next;

    fsm_seq_next_lut #(
        .LEN     (LEN),
        .PATTERN (PATTERN),
        .OVERLAP (OVERLAP),
        .SW      (SW)
    ) u_next_lut (
        .state      (state_reg),
        .in         (in),
        .state_next (lut_next)
    );

    always_comb begin
        state_next = state_reg;
        if (en) begin
            state_next = lut_next;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_reg <= '0;
        end else begin
            state_reg <= state_next;
        end
    end

    assign out     = (state_reg == SW'(LEN));
    assign state_o = state_reg;

`ifdef FSM_MATCH_COUNT_EN
    logic [CNT_W-1:0] cnt_reg;

    // Counts on the edge that enters the full-match state, so it lines up with out.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            cnt_reg <= '0;
        end else if (en && lut_next == SW'(LEN) && cnt_reg != '1) begin
            cnt_reg <= cnt_reg + CNT_W'(1);
        end
    end

    assign match_cnt = cnt_reg;
`endif

endmodule

// File: tb/tb_fsm_seq_det.sv
// Bench for fsm_seq_det: directed scenarios plus random bits, checked against
// a suffix-matching reference model over the accepted bit history.
module tb_fsm_seq_det;

    localparam logic [3:0] PAT = 4'b1011;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       en = 1'b0;
    logic       din = 1'b0;
    logic       out_a, out_b, out_c;
    logic [2:0] st_a, st_b, st_c;
`ifdef FSM_MATCH_COUNT_EN
    logic [7:0] cnt_a, cnt_b;
    logic [1:0] cnt_c;
`endif

    int errors = 0;
    int checks = 0;

    bit hist_a[$];
    bit hist_b[$];
    int exp_a = 0, exp_b = 0;
    int exp_cnt_a = 0, exp_cnt_b = 0, exp_cnt_c = 0;

    always #5 clk = ~clk;

    fsm_seq_det #(.LEN(4), .PATTERN(4'b1011), .OVERLAP(1), .CNT_W(8)) dut_a (
        .clk(clk), .resetn(resetn), .en(en), .in(din), .out(out_a), .state_o(st_a)
`ifdef FSM_MATCH_COUNT_EN
        , .match_cnt(cnt_a)
`endif
    );

    fsm_seq_det #(.LEN(4), .PATTERN(4'b1011), .OVERLAP(0), .CNT_W(8)) dut_b (
        .clk(clk), .resetn(resetn), .en(en), .in(din), .out(out_b), .state_o(st_b)
`ifdef FSM_MATCH_COUNT_EN
        , .match_cnt(cnt_b)
`endif
    );

    fsm_seq_det #(.LEN(4), .PATTERN(4'b1011), .OVERLAP(1), .CNT_W(2)) dut_c (
        .clk(clk), .resetn(resetn), .en(en), .in(din), .out(out_c), .state_o(st_c)
`ifdef FSM_MATCH_COUNT_EN
        , .match_cnt(cnt_c)
`endif
    );

    // Longest suffix of the history that equals a prefix of the pattern.
    function automatic int ref_state(input bit h[$]);
        int n;
        bit ok;
        n = h.size();
        for (int k = (n < 4) ? n : 4; k > 0; k--) begin
            ok = 1'b1;
            for (int j = 0; j < k; j++) begin
                if (h[n-k+j] != PAT[3-j]) ok = 1'b0;
            end
            if (ok) return k;
        end
        return 0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, " state_a"}, 32'(st_a), 32'(exp_a));
        chk({tag, " out_a"},   32'(out_a), 32'(exp_a == 4));
        chk({tag, " state_b"}, 32'(st_b), 32'(exp_b));
        chk({tag, " out_b"},   32'(out_b), 32'(exp_b == 4));
        chk({tag, " state_c"}, 32'(st_c), 32'(exp_a));
`ifdef FSM_MATCH_COUNT_EN
        chk({tag, " cnt_a"}, 32'(cnt_a), 32'(exp_cnt_a));
        chk({tag, " cnt_b"}, 32'(cnt_b), 32'(exp_cnt_b));
        chk({tag, " cnt_c"}, 32'(cnt_c), 32'(exp_cnt_c));
`endif
    endtask

    task automatic step(input bit e, input bit b, input string tag);
        en  = e;
        din = b;
        @(posedge clk);
        if (e) begin
            hist_a.push_back(b);
            while (hist_a.size() > 4) void'(hist_a.pop_front());
            exp_a = ref_state(hist_a);
            if (exp_b == 4) hist_b.delete();
            hist_b.push_back(b);
            while (hist_b.size() > 4) void'(hist_b.pop_front());
            exp_b = ref_state(hist_b);
            if (exp_a == 4 && exp_cnt_a < 255) exp_cnt_a++;
            if (exp_a == 4 && exp_cnt_c < 3)   exp_cnt_c++;
            if (exp_b == 4 && exp_cnt_b < 255) exp_cnt_b++;
        end
        #1;
        $display("step %s: en=%0b in=%0b state_a=%0d out_a=%0b state_b=%0d out_b=%0b",
                 tag, e, b, st_a, out_a, st_b, out_b);
        check_all(tag);
    endtask

    task automatic do_reset(input string tag);
        resetn = 1'b0;
        en     = 1'b1;
        din    = 1'b1;
        @(posedge clk);
        hist_a.delete();
        hist_b.delete();
        exp_a = 0; exp_b = 0;
        exp_cnt_a = 0; exp_cnt_b = 0; exp_cnt_c = 0;
        #1;
        $display("reset %s: state_a=%0d out_a=%0b", tag, st_a, out_a);
        check_all(tag);
        resetn = 1'b1;
    endtask

    initial begin
        bit seq28[7] = '{1, 0, 1, 1, 0, 1, 1};
        bit seq29[5] = '{1, 1, 0, 1, 1};
        int st29[5]  = '{1, 1, 2, 3, 4};
        int sat32[5] = '{1, 2, 3, 3, 3};
        bit p1011[4] = '{1, 0, 1, 1};
        int pulses_a, pulses_b;

        do_reset("init_reset");

        // Basic match, then fallback from the full state.
        for (int i = 0; i < 4; i++) step(1'b1, p1011[i], "basic");
        chk("basic state4", 32'(st_a), 32'd4);
        chk("basic out", 32'(out_a), 32'd1);
        step(1'b1, 1'b0, "basic_fallback");
        chk("basic fallback state", 32'(st_a), 32'd2);
        chk("basic out cleared", 32'(out_a), 32'd0);

        // Overlapping vs restarting detection.
        do_reset("ovl_reset");
        pulses_a = 0;
        pulses_b = 0;
        for (int i = 0; i < 7; i++) begin
            step(1'b1, seq28[i], "ovl");
            pulses_a += int'(out_a);
            pulses_b += int'(out_b);
        end
        chk("ovl pulses overlap1", 32'(pulses_a), 32'd2);
        chk("ovl pulses overlap0", 32'(pulses_b), 32'd1);

        // Mismatch on second bit falls back to 1, not 0.
        do_reset("fb_reset");
        for (int i = 0; i < 5; i++) begin
            step(1'b1, seq29[i], "fb");
            chk($sformatf("fb state bit%0d", i + 1), 32'(st_a), 32'(st29[i]));
        end
        chk("fb out", 32'(out_a), 32'd1);

        // Enable low holds the partial match.
        do_reset("en_reset");
        step(1'b1, 1'b1, "en");
        step(1'b1, 1'b0, "en");
        for (int i = 0; i < 3; i++) begin
            step(1'b0, bit'(i % 2 == 0), "en_hold");
            chk("en hold state", 32'(st_a), 32'd2);
        end
        step(1'b1, 1'b1, "en");
        step(1'b1, 1'b1, "en");
        chk("en final out", 32'(out_a), 32'd1);

        // Reset mid-sequence discards the partial match.
        do_reset("mid_reset0");
        step(1'b1, 1'b1, "mid");
        step(1'b1, 1'b0, "mid");
        step(1'b1, 1'b1, "mid");
        do_reset("mid_reset");
        chk("mid state after reset", 32'(st_a), 32'd0);
        step(1'b1, 1'b1, "mid_after");
        chk("mid state after bit", 32'(st_a), 32'd1);
        chk("mid out", 32'(out_a), 32'd0);

`ifdef FSM_MATCH_COUNT_EN
        // Narrow counter saturates instead of wrapping.
        do_reset("sat_reset");
        for (int m = 0; m < 5; m++) begin
            for (int i = 0; i < 4; i++) step(1'b1, p1011[i], "sat");
            chk($sformatf("sat cnt match%0d", m + 1), 32'(cnt_c), 32'(sat32[m]));
        end
`endif

        do_reset("rand_reset");
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 39) == 0) do_reset("rand_rst");
            else step($urandom_range(0, 3) != 0, bit'($urandom_range(0, 1)), "rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fsm_seq_det.md
FSM_SEQ_DET -- requirements
Module: fsm_seq_det

Interface
REQ-001 SHALL have parameter LEN, default 4, pattern length in bits (2..16).
REQ-002 SHALL have parameter PATTERN, default 4'b1011, LEN-bit pattern, matched MSB first.
REQ-003 SHALL have parameter OVERLAP, default 1; 1 allows overlapping matches, 0 restarts after a match.
REQ-004 SHALL have parameter CNT_W, default 8, match-counter width.
REQ-005 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-006 SHALL have port resetn  input  1  reset, synchronous, active-low.
REQ-007 SHALL have port en  input  1  sample enable; in is consumed only when en=1.
REQ-008 SHALL have port in  input  1  serial data bit.
REQ-009 SHALL have port out  output  1  Moore match flag, high while state==LEN.
REQ-010 SHALL have port state_o  output  SW=$clog2(LEN+1)  current matched-prefix length.
REQ-011 SHALL have port match_cnt  output  CNT_W  saturating match count (present only with FSM_MATCH_COUNT_EN).

Function
REQ-012 SHALL hold state S in 0..LEN, S = number of leading PATTERN bits currently matched.
REQ-013 SHALL, for S<LEN with en=1, go to S+1 if in==PATTERN[LEN-1-S], else to the longest proper prefix of the pattern that is a suffix of the matched bits followed by in (KMP fallback, possibly 0).
REQ-014 SHALL, for S==LEN with en=1 and OVERLAP=1, apply the REQ-013 fallback from the longest proper border of PATTERN.
REQ-015 SHALL, for S==LEN with en=1 and OVERLAP=0, evaluate in as from S=0 (next is 1 or 0).
REQ-016 SHALL hold S, out and match_cnt unchanged when en=0.
REQ-017 SHALL drive out purely from state: high exactly the cycle after the edge that sampled the final pattern bit; one-cycle pulse unless another match follows immediately.
REQ-018 SHALL compute all fallback targets at elaboration from PATTERN; no runtime pattern storage.
REQ-019 SHALL never reach a state >LEN; unused SW encodings SHALL map to 0 on the next enabled edge.

Reset
REQ-020 SHALL, when resetn=0 at a clk edge, set S=0, out=0, match_cnt=0, overriding en and in.
REQ-021 SHALL discard any partial match on reset mid-sequence; the first post-reset sample is evaluated from S=0.

Configuration
REQ-022 SHALL compile match_cnt and its counter only when macro FSM_MATCH_COUNT_EN is defined.
REQ-023 SHALL, with FSM_MATCH_COUNT_EN, increment match_cnt on every enabled edge whose next state is LEN, saturating at all-ones (no wrap).
REQ-024 SHALL, without FSM_MATCH_COUNT_EN, omit the match_cnt port and counter; all other behaviour is identical.

Structure
REQ-025 SHALL place the state-width constant/function and the elaboration-time fallback (border) function in shared package fsm_seq_pkg.
REQ-026 SHALL use one combinational sub-module fsm_seq_next_lut (inputs S, in; output next S) holding the transition table; state register, out and counter live in fsm_seq_det.

Verification
REQ-027 SHALL cover: defaults, reset, en=1, in=1,0,1,1 -> out=1 in the cycle after the 4th edge only, state_o=4 there, then state_o follows fallback.
REQ-028 SHALL cover: in=1,0,1,1,0,1,1 with OVERLAP=1 -> two out pulses (after bits 4 and 7); with OVERLAP=0 -> one pulse (after bit 4).
REQ-029 SHALL cover: fallback, in=1,1,0,1,1 -> state_o 1,1,2,3,4, out pulse after bit 5.
REQ-030 SHALL cover: in=1,0, then en=0 for 3 cycles with in toggling, then en=1 with in=1,1 -> state_o holds 2 while en=0, match after final bit.
REQ-031 SHALL cover: in=1,0,1 then resetn=0 for one edge, then in=1 -> state_o=0 after reset, state_o=1 after, no out pulse.
REQ-032 SHALL cover (FSM_MATCH_COUNT_EN, CNT_W=2): five back-to-back 1011 matches -> match_cnt 1,2,3,3,3.
